// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch / load-store RAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// Pure grant decision between fetch and load/store requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise fixed LS priority with a fetch starvation guard.
module mem_arb_pick
    import mem_arb_pkg::*;
`ifdef MEM_ARB_RR_EN
(
    input  logic   if_req_i,
    input  logic   ls_req_i,
    input  owner_t last_winner_i,
    output logic   gnt_if_o,
    output logic   gnt_ls_o
);
`else
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             if_req_i,
    input  logic             ls_req_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic             gnt_if_o,
    output logic             gnt_ls_o
);
`endif

    always_comb begin
        gnt_if_o = 1'b0;
        gnt_ls_o = 1'b0;
        if (if_req_i && ls_req_i) begin
`ifdef MEM_ARB_RR_EN
            // Whoever did not win last time takes this contested cycle.
            if (last_winner_i == OWN_IF) begin
                gnt_ls_o = 1'b1;
            end else begin
                gnt_if_o = 1'b1;
            end
`else
            if (starve_cnt_i == CNT_W'(STARVE_LIMIT)) begin
                gnt_if_o = 1'b1;
            end else begin
                gnt_ls_o = 1'b1;
            end
`endif
        end else begin
            gnt_if_o = if_req_i;
            gnt_ls_o = ls_req_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch (read-only) and load/store, with one-cycle read return routing.
// Optional macro MEM_ARB_RR_EN: round-robin arbitration instead of fixed LS priority with starvation guard.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i
);

    logic   if_req;
    logic   ls_req;
    logic   gnt_if;
    logic   gnt_ls;
    owner_t rsp_owner_q;
    owner_t rsp_owner_d;

    // Masking requests during reset keeps every grant and RAM pin at zero.
    assign if_req = if_req_i & ~reset;
    assign ls_req = ls_req_i & ~reset;

`ifdef MEM_ARB_RR_EN
    owner_t last_winner_q;
    owner_t last_winner_d;

    mem_arb_pick u_pick (
        .if_req_i      (if_req),
        .ls_req_i      (ls_req),
        .last_winner_i (last_winner_q),
        .gnt_if_o      (gnt_if),
        .gnt_ls_o      (gnt_ls)
    );

    always_comb begin
        last_winner_d = last_winner_q;
        if (gnt_if) begin
            last_winner_d = OWN_IF;
        end else if (gnt_ls) begin
            last_winner_d = OWN_LS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner_q <= OWN_LS;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .if_req_i     (if_req),
        .ls_req_i     (ls_req),
        .starve_cnt_i (starve_cnt_q),
        .gnt_if_o     (gnt_if),
        .gnt_ls_o     (gnt_ls)
    );

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt_if) begin
            starve_cnt_d = '0;
        end else if (if_req && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    always_comb begin
        rsp_owner_d = OWN_NONE;
        if (gnt_if) begin
            rsp_owner_d = OWN_IF;
        end else if (gnt_ls && !ls_we_i) begin
            rsp_owner_d = OWN_LS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_owner_q <= OWN_NONE;
        end else begin
            rsp_owner_q <= rsp_owner_d;
        end
    end

    assign if_gnt_o = gnt_if;
    assign ls_gnt_o = gnt_ls;
    assign we_o     = gnt_ls & ls_we_i;
    assign addr_o   = gnt_if ? if_addr_i : (gnt_ls ? ls_addr_i : '0);
    assign data_o   = (gnt_ls && ls_we_i) ? ls_wdata_i : '0;

    // Gating with reset drops a response whose owner was latched just before reset rose.
    assign if_rvalid_o = (rsp_owner_q == OWN_IF) & ~reset;
    assign ls_rvalid_o = (rsp_owner_q == OWN_LS) & ~reset;
    assign if_rdata_o  = if_rvalid_o ? data_i : '0;
    assign ls_rdata_o  = ls_rvalid_o ? data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural RAM and arbitration model.
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          ls_req_i;
    logic          ls_we_i;
    logic [AW-1:0] ls_addr_i;
    logic [DW-1:0] ls_wdata_i;
    logic          ls_gnt_o;
    logic          ls_rvalid_o;
    logic [DW-1:0] ls_rdata_o;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_o;
    logic [DW-1:0] data_i;

    mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .data_i      (data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic        gi;
        logic        gl;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    rsp_t if_q[$];
    rsp_t ls_q[$];
    bus_t bus_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    function automatic logic [31:0] init_val(int idx);
        return (32'h1357_0000 + 32'(idx) * 32'h0001_0203) ^ 32'h5A00_00A5;
    endfunction

    // Behavioural single-port RAM: read data appears the cycle after the address.
    logic [31:0] ram[256];
    bit          ram_ready = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else begin
            data_i <= ram[addr_o[9:2]];
            if (we_o) ram[addr_o[9:2]] <= data_o;
        end
    end

    // Reference model state: pending requests, arbitration history, memory contents.
    bit          if_pend = 0, ls_pend = 0, ls_w = 0;
    logic [31:0] if_a = 0, ls_a = 0, ls_wd = 0;
    int          if_wait = 0;
    bit          last_if = 0;
    logic [31:0] ref_mem[256];

    task automatic cycle_step(input bit rst, input bit new_if, input logic [31:0] ia,
                              input bit new_ls, input bit lwe, input logic [31:0] la,
                              input logic [31:0] wd);
        bus_t e;
        rsp_t r;
        bit   g_if;
        bit   g_ls;
        @(posedge clk);
        #1;
        if (new_if && !if_pend) begin
            if_pend = 1; if_a = ia;
        end
        if (new_ls && !ls_pend) begin
            ls_pend = 1; ls_w = lwe; ls_a = la; ls_wd = lwe ? wd : 32'h0;
        end
        reset      = rst;
        if_req_i   = if_pend;
        if_addr_i  = if_a;
        ls_req_i   = ls_pend;
        ls_we_i    = ls_w;
        ls_addr_i  = ls_a;
        ls_wdata_i = ls_wd;
        g_if = 0;
        g_ls = 0;
        if (rst) begin
            if_q.delete();
            ls_q.delete();
            if_wait = 0;
            last_if = 0;
        end else if (if_pend && ls_pend) begin
`ifdef MEM_ARB_RR_EN
            g_if = !last_if;
`else
            g_if = (if_wait >= LIMIT);
`endif
            g_ls = !g_if;
        end else begin
            g_if = if_pend;
            g_ls = ls_pend;
        end
        e.gi = g_if; e.gl = g_ls; e.we = 0; e.addr = 0; e.data = 0;
        if (g_if) begin
            e.addr = if_a;
            r.due = cyc + 1; r.data = ref_mem[if_a[9:2]];
            if_q.push_back(r);
            if_pend = 0; last_if = 1; if_wait = 0;
        end else if (if_pend && !rst) begin
            if_wait = (if_wait < LIMIT) ? if_wait + 1 : LIMIT;
        end
        if (g_ls) begin
            e.addr = ls_a;
            if (ls_w) begin
                e.we = 1; e.data = ls_wd;
                ref_mem[ls_a[9:2]] = ls_wd;
            end else begin
                r.due = cyc + 1; r.data = ref_mem[ls_a[9:2]];
                ls_q.push_back(r);
            end
            ls_pend = 0; last_if = 0;
        end
        bus_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle_step(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] raddr();
        return 32'($urandom_range(0, 255)) << 2;
    endfunction

    // Monitor: compares the RAM pins and routes read returns against the scoreboard.
    always @(negedge clk) begin
        bus_t e;
        if (bus_q.size() > 0) begin
            e = bus_q.pop_front();
            checks++;
            if ({if_gnt_o, ls_gnt_o, we_o, addr_o, data_o} !== {e.gi, e.gl, e.we, e.addr, e.data}) begin
                errors++;
                $display("FAIL bus cyc=%0d got gi=%0b gl=%0b we=%0b addr=%h data=%h need gi=%0b gl=%0b we=%0b addr=%h data=%h",
                         cyc, if_gnt_o, ls_gnt_o, we_o, addr_o, data_o, e.gi, e.gl, e.we, e.addr, e.data);
            end
        end
        if (if_rvalid_o) begin
            checks++;
            if (if_q.size() > 0 && if_q[0].due == cyc) begin
                if (if_rdata_o !== if_q[0].data) begin
                    errors++;
                    $display("FAIL if_rdata cyc=%0d got %h need %h", cyc, if_rdata_o, if_q[0].data);
                end
                void'(if_q.pop_front());
            end else begin
                errors++;
                $display("FAIL if_rvalid cyc=%0d got 1 need 0", cyc);
            end
        end else begin
            checks++;
            if (if_rdata_o !== 32'h0) begin
                errors++;
                $display("FAIL if_rdata_idle cyc=%0d got %h need 0", cyc, if_rdata_o);
            end
            if (if_q.size() > 0 && if_q[0].due <= cyc) begin
                errors++;
                $display("FAIL if_rvalid cyc=%0d got 0 need 1", cyc);
                void'(if_q.pop_front());
            end
        end
        if (ls_rvalid_o) begin
            checks++;
            if (ls_q.size() > 0 && ls_q[0].due == cyc) begin
                if (ls_rdata_o !== ls_q[0].data) begin
                    errors++;
                    $display("FAIL ls_rdata cyc=%0d got %h need %h", cyc, ls_rdata_o, ls_q[0].data);
                end
                void'(ls_q.pop_front());
            end else begin
                errors++;
                $display("FAIL ls_rvalid cyc=%0d got 1 need 0", cyc);
            end
        end else begin
            checks++;
            if (ls_rdata_o !== 32'h0) begin
                errors++;
                $display("FAIL ls_rdata_idle cyc=%0d got %h need 0", cyc, ls_rdata_o);
            end
            if (ls_q.size() > 0 && ls_q[0].due <= cyc) begin
                errors++;
                $display("FAIL ls_rvalid cyc=%0d got 0 need 1", cyc);
                void'(ls_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1; if_req_i = 0; if_addr_i = 0;
        ls_req_i = 0; ls_we_i = 0; ls_addr_i = 0; ls_wdata_i = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (2) @(posedge clk);

        // Reset held two cycles with both requests up, then release.
        cycle_step(1, 1, 32'h10, 1, 0, 32'h20, 0);
        cycle_step(1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Back-to-back fetches.
        cycle_step(0, 1, 32'h100, 0, 0, 0, 0);
        cycle_step(0, 1, 32'h104, 0, 0, 0, 0);
        idle(2);

        // Store while fetch is requesting, then read it back.
        cycle_step(0, 1, 32'h300, 1, 1, 32'h200, 32'hDEADBEEF);
        idle(3);
        cycle_step(0, 0, 0, 1, 0, 32'h200, 0);
        idle(2);

        // Both held high from reset: starvation pattern or alternation.
        cycle_step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle_step(0, 1, raddr(), 1, 0, raddr(), 0);
        idle(3);

        // Reset the cycle after a fetch grant drops its response.
        cycle_step(0, 1, 32'h104, 0, 0, 0, 0);
        cycle_step(1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Random traffic with occasional mid-operation resets.
        for (int i = 0; i < 400; i++) begin
            cycle_step($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, raddr(),
                       $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, raddr(), $urandom());
        end
        idle(4);
        @(negedge clk);
        #1;
        checks++;
        if (if_q.size() + ls_q.size() + bus_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d outstanding need 0", if_q.size() + ls_q.size() + bus_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
